// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the fully connected output-layer post-processing.
//   argmax_state_t : FSM encoding of the argmax classifier (IDLE/SCAN/HOLD)
//   MOST_NEG(w)    : most negative w-bit two's complement value (w <= 64)
//   MAX_POS(w)     : most positive w-bit two's complement value (w <= 64)
// The constant functions return 64-bit patterns; callers cast to their width.
// -----------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } argmax_state_t;

    function automatic logic [63:0] MOST_NEG(input int w);
        return 64'(1) << (w - 1);
    endfunction

    function automatic logic [63:0] MAX_POS(input int w);
        return (64'(1) << (w - 1)) - 64'(1);
    endfunction

endpackage

// File: rtl/argmax_update.sv
// -----------------------------------------------------------------------------
// argmax_update
// Combinational top-1/top-2 tracker step: folds one element into the running
// best / second-best pair.
//   i_x       : element being scanned (signed)
//   i_cnt     : position of i_x in the vector
//   i_best    : current maximum
//   i_second  : current second-largest value
//   i_idx     : index of current maximum
//   o_best    : updated maximum
//   o_second  : updated second-largest value
//   o_idx     : updated index of maximum
// A tie with the maximum keeps the earlier index and drags second up to the
// same value, so duplicates of the winner yield a zero margin.
// -----------------------------------------------------------------------------
module argmax_update #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
) (
    input  logic signed [WIDTH-1:0] i_x,
    input  logic        [IDX_W-1:0] i_cnt,
    input  logic signed [WIDTH-1:0] i_best,
    input  logic signed [WIDTH-1:0] i_second,
    input  logic        [IDX_W-1:0] i_idx,
    output logic signed [WIDTH-1:0] o_best,
    output logic signed [WIDTH-1:0] o_second,
    output logic        [IDX_W-1:0] o_idx
);

    always_comb begin
        o_best   = i_best;
        o_second = i_second;
        o_idx    = i_idx;
        if (i_x > i_best) begin
            o_second = i_best;
            o_best   = i_x;
            o_idx    = i_cnt;
        end else if (i_x > i_second) begin
            // Also covers i_x == i_best: strict compare above keeps the index.
            o_second = i_x;
        end
    end

endmodule

// File: rtl/fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// fc_argmax_classifier
// Terminal stage of the inference datapath. Captures one vector of signed
// fully connected outputs, scans it one element per clock and reports the
// winning class, its value and the saturated top-1 minus top-2 margin.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_vec holds a vector
//   in_ready   : block can accept a vector (IDLE only)
//   in_vec     : LENGTH signed WIDTH-bit elements
//   out_valid  : result fields valid (HOLD)
//   out_ready  : consumer accepts the result
//   out_index  : argmax index (lowest index wins ties)
//   out_value  : maximum value
//   out_margin : best - second, saturated to the positive range
// Only one vector is in flight; a new one is accepted only after the result
// has been consumed and the FSM has spent one cycle back in IDLE.
// -----------------------------------------------------------------------------
module fc_argmax_classifier
    import fc_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int FRAC_BITS = 16,
    parameter  int LENGTH    = 16,
    localparam int IDX_W     = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_vec [0:LENGTH-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [IDX_W-1:0] out_index,
    output logic signed [WIDTH-1:0] out_value,
    output logic signed [WIDTH-1:0] out_margin
);

    // The fixed-point format does not affect ordering; it is only sanity-checked.
    if (LENGTH < 1 || WIDTH < 2 || WIDTH > 64 || FRAC_BITS < 0 || FRAC_BITS >= WIDTH) begin : g_bad_cfg
        $error("fc_argmax_classifier: unsupported WIDTH/FRAC_BITS/LENGTH");
    end

    localparam logic signed [WIDTH-1:0] C_MOST_NEG = WIDTH'(MOST_NEG(WIDTH));
    localparam logic signed [WIDTH-1:0] C_MAX_POS  = WIDTH'(MAX_POS(WIDTH));

    // best - second never goes negative, but can exceed the signed range
    // (e.g. MAX_POS - MOST_NEG), so it is formed one bit wider and clamped.
    function automatic logic signed [WIDTH-1:0] sat_margin(
        input logic signed [WIDTH-1:0] best,
        input logic signed [WIDTH-1:0] second
    );
        logic signed [WIDTH:0] diff;
        diff = {best[WIDTH-1], best} - {second[WIDTH-1], second};
        if (diff > $signed({1'b0, C_MAX_POS}))
            return C_MAX_POS;
        else
            return diff[WIDTH-1:0];
    endfunction

    argmax_state_t           r_state;
    logic signed [WIDTH-1:0] r_vec [0:LENGTH-1];
    logic        [IDX_W-1:0] r_cnt;
    logic        [IDX_W-1:0] r_idx;
    logic signed [WIDTH-1:0] r_best;
    logic signed [WIDTH-1:0] r_second;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic        [IDX_W-1:0] r_out_index;
    logic signed [WIDTH-1:0] r_out_value;
    logic signed [WIDTH-1:0] r_out_margin;

    logic signed [WIDTH-1:0] w_x;
    logic signed [WIDTH-1:0] w_nbest;
    logic signed [WIDTH-1:0] w_nsecond;
    logic        [IDX_W-1:0] w_nidx;
    logic                    w_last;

    // With a single class there is nothing to scan and no index to decode.
    if (LENGTH > 1) begin : g_sel
        assign w_x = r_vec[r_cnt];
    end else begin : g_one
        assign w_x = r_vec[0];
    end

    assign w_last = (r_cnt == IDX_W'(LENGTH - 1));

    argmax_update #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_update (
        .i_x      (w_x),
        .i_cnt    (r_cnt),
        .i_best   (r_best),
        .i_second (r_second),
        .i_idx    (r_idx),
        .o_best   (w_nbest),
        .o_second (w_nsecond),
        .o_idx    (w_nidx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_best       <= '0;
            r_second     <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_out_value  <= '0;
            r_out_margin <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                r_vec[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        for (int i = 0; i < LENGTH; i++) begin
                            r_vec[i] <= in_vec[i];
                        end
                        r_best     <= in_vec[0];
                        r_second   <= C_MOST_NEG;
                        r_idx      <= '0;
                        r_cnt      <= IDX_W'(1);
                        r_in_ready <= 1'b0;
                        if (LENGTH == 1) begin
                            r_state      <= HOLD;
                            r_out_valid  <= 1'b1;
                            r_out_index  <= '0;
                            r_out_value  <= in_vec[0];
                            r_out_margin <= C_MAX_POS;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end

                SCAN: begin
                    r_best   <= w_nbest;
                    r_second <= w_nsecond;
                    r_idx    <= w_nidx;
                    if (w_last) begin
                        // Result fields take the post-update values of the last element.
                        r_state      <= HOLD;
                        r_out_valid  <= 1'b1;
                        r_out_index  <= w_nidx;
                        r_out_value  <= w_nbest;
                        r_out_margin <= sat_margin(w_nbest, w_nsecond);
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end

                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_index  = r_out_index;
    assign out_value  = r_out_value;
    assign out_margin = r_out_margin;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_fc_argmax_classifier
// Table-driven and scoreboard-based bench for fc_argmax_classifier. A default
// (LENGTH=16) instance carries most vectors; a LENGTH=1 instance covers the
// degenerate single-class configuration.
// -----------------------------------------------------------------------------
module tb_fc_argmax_classifier;

    localparam int W = 32;
    localparam int L = 16;

    typedef struct {
        logic [L-1:0][W-1:0] v;
        logic [3:0]          idx;
        logic [W-1:0]        val;
        logic [W-1:0]        mar;
    } vec_rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic                 in_valid  = 1'b0;
    logic                 in_ready;
    logic signed [W-1:0]  in_vec [0:L-1];
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic        [3:0]    out_index;
    logic signed [W-1:0]  out_value;
    logic signed [W-1:0]  out_margin;

    logic                 in_valid1  = 1'b0;
    logic                 in_ready1;
    logic signed [W-1:0]  in_vec1 [0:0];
    logic                 out_valid1;
    logic                 out_ready1 = 1'b0;
    logic        [0:0]    out_index1;
    logic signed [W-1:0]  out_value1;
    logic signed [W-1:0]  out_margin1;

    int n_checks = 0;
    int n_fail   = 0;

    vec_rec_t sb[$];

    always #5 clk = ~clk;

    fc_argmax_classifier #(
        .WIDTH     (W),
        .FRAC_BITS (16),
        .LENGTH    (L)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_value  (out_value),
        .out_margin (out_margin)
    );

    fc_argmax_classifier #(
        .WIDTH     (W),
        .FRAC_BITS (16),
        .LENGTH    (1)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_vec     (in_vec1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .out_index  (out_index1),
        .out_value  (out_value1),
        .out_margin (out_margin1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: first occurrence of the maximum, then the largest of the
    // remaining elements (duplicates of the maximum included).
    function automatic vec_rec_t model(input logic [L-1:0][W-1:0] v);
        vec_rec_t r;
        int       bi;
        longint   best;
        longint   second;
        longint   diff;
        bi = 0;
        for (int i = 1; i < L; i++)
            if ($signed(v[i]) > $signed(v[bi])) bi = i;
        best   = longint'($signed(v[bi]));
        second = -(64'sd1 <<< 31);
        for (int i = 0; i < L; i++)
            if (i != bi && longint'($signed(v[i])) > second) second = longint'($signed(v[i]));
        diff = best - second;
        if (diff > 64'sh7FFF_FFFF) diff = 64'sh7FFF_FFFF;
        r.v   = v;
        r.idx = 4'(bi);
        r.val = v[bi];
        r.mar = diff[31:0];
        return r;
    endfunction

    // Drive one vector, push its expectation, return just after the accept edge.
    task automatic send(input vec_rec_t r);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("send_in_ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        for (int i = 0; i < L; i++) in_vec[i] = r.v[i];
        in_valid = 1'b1;
        sb.push_back(r);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < L; i++) in_vec[i] = 32'h5A5A_5A5A;
    endtask

    // Wait for the result, compare with the scoreboard, hold out_ready low
    // for 'hold' cycles checking stability, then consume the result.
    task automatic collect(input string tag, input int exp_lat, input int hold);
        int       k;
        vec_rec_t e;
        k = 0;
        while (out_valid !== 1'b1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (out_valid !== 1'b1) begin
            chk({tag, "_result_timeout"}, {31'd0, out_valid}, 32'd1);
            return;
        end
        chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
        chk({tag, "_in_ready_hold"}, {31'd0, in_ready}, 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_result"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_index"},  {28'd0, out_index}, {28'd0, e.idx});
        chk({tag, "_value"},  out_value,  e.val);
        chk({tag, "_margin"}, out_margin, e.mar);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_valid"},    {31'd0, out_valid}, 32'd1);
            chk({tag, "_bp_in_ready"}, {31'd0, in_ready},  32'd0);
            chk({tag, "_bp_index"},    {28'd0, out_index}, {28'd0, e.idx});
            chk({tag, "_bp_value"},    out_value,  e.val);
            chk({tag, "_bp_margin"},   out_margin, e.mar);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"},    {31'd0, out_valid}, 32'd0);
        chk({tag, "_in_ready_back"}, {31'd0, in_ready},  32'd1);
        chk({tag, "_value_kept"},    out_value, e.val);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_rec_t tbl [8];
        vec_rec_t r;
        logic [L-1:0][W-1:0] v;
        bit saw_valid;

        for (int i = 0; i < L; i++) in_vec[i] = '0;
        in_vec1[0] = '0;

        // Test-plan vectors and a few scan-order corners; expectations by hand.
        tbl[0].v = '0; tbl[0].v[0] = 32'h0001_0000; tbl[0].v[1] = 32'h0003_8000;
        tbl[0].v[2] = 32'hFFFE_0000; tbl[0].v[3] = 32'h0003_0000;
        tbl[0].idx = 4'd1;  tbl[0].val = 32'h0003_8000; tbl[0].mar = 32'h0000_8000;

        tbl[1].v = '0; tbl[1].v[4] = 32'h0002_0000; tbl[1].v[9] = 32'h0002_0000;
        tbl[1].idx = 4'd4;  tbl[1].val = 32'h0002_0000; tbl[1].mar = 32'h0;

        for (int i = 0; i < L; i++) tbl[2].v[i] = 32'hFFFF_FF00;
        tbl[2].v[7] = 32'hFFFF_FFF0;
        tbl[2].idx = 4'd7;  tbl[2].val = 32'hFFFF_FFF0; tbl[2].mar = 32'h0000_00F0;

        for (int i = 0; i < L; i++) tbl[3].v[i] = 32'h8000_0000;
        tbl[3].v[0] = 32'h7FFF_FFFF;
        tbl[3].idx = 4'd0;  tbl[3].val = 32'h7FFF_FFFF; tbl[3].mar = 32'h7FFF_FFFF;

        for (int i = 0; i < L; i++) tbl[4].v[i] = 32'd5;
        tbl[4].idx = 4'd0;  tbl[4].val = 32'd5; tbl[4].mar = 32'd0;

        for (int i = 0; i < L; i++) tbl[5].v[i] = 32'd1;
        tbl[5].v[15] = 32'd100;
        tbl[5].idx = 4'd15; tbl[5].val = 32'd100; tbl[5].mar = 32'd99;

        tbl[6].v = '0; tbl[6].v[0] = 32'd50; tbl[6].v[15] = 32'd40;
        tbl[6].idx = 4'd0;  tbl[6].val = 32'd50; tbl[6].mar = 32'd10;

        tbl[7].v = '0; tbl[7].v[3] = 32'd10; tbl[7].v[15] = 32'd20; tbl[7].v[8] = 32'hFFFF_FFFF;
        tbl[7].idx = 4'd15; tbl[7].val = 32'd20; tbl[7].mar = 32'd10;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_out_index",  {28'd0, out_index},  32'd0);
        chk("rst_out_value",  out_value,  32'd0);
        chk("rst_out_margin", out_margin, 32'd0);
        chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_in_ready1", {31'd0, in_ready1}, 32'd1);

        // Table vectors, consumed immediately
        for (int t = 0; t < 8; t++) begin
            send(tbl[t]);
            collect($sformatf("tbl%0d", t), L - 1, 0);
        end

        // Random vectors against the reference model; narrow range forces ties
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < L; i++) begin
                if (t < 3) v[i] = 32'(int'($urandom_range(0, 15)) - 8);
                else       v[i] = $urandom;
            end
            r = model(v);
            send(r);
            collect($sformatf("rnd%0d", t), L - 1, 0);
        end

        // Backpressure: result held for 20 cycles
        send(tbl[0]);
        collect("bp", L - 1, 20);

        // Reset in the middle of a scan discards the vector
        send(tbl[5]);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_value", out_value, 32'd0);
        chk("midrst_out_index", {28'd0, out_index}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        saw_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        chk("midrst_no_result", {31'd0, saw_valid}, 32'd0);
        send(tbl[2]);
        collect("post_rst", L - 1, 0);

        // Single-class configuration
        @(negedge clk);
        chk("len1_in_ready", {31'd0, in_ready1}, 32'd1);
        in_vec1[0] = 32'hFFFF_0000;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        in_vec1[0] = 32'h0;
        chk("len1_valid",    {31'd0, out_valid1}, 32'd1);
        chk("len1_in_ready_hold", {31'd0, in_ready1}, 32'd0);
        chk("len1_index",    {31'd0, out_index1}, 32'd0);
        chk("len1_value",    out_value1,  32'hFFFF_0000);
        chk("len1_margin",   out_margin1, 32'h7FFF_FFFF);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        chk("len1_valid_drop", {31'd0, out_valid1}, 32'd0);
        chk("len1_in_ready_back", {31'd0, in_ready1}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
